// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: direct per-cycle control plus a
// multi-step shift/rotate sequencer with a busy/done handshake.
module univ_shift_reg #(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] p,
  input  logic             sil,
  input  logic             sir,
  input  logic             start,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  op_e              mode_q, mode_d;
  logic             done_q, done_d;

  op_e  s_op;
  logic fixed_op;

  function automatic logic [WIDTH-1:0] step_op(
    input op_e              op,
    input logic [WIDTH-1:0] cur,
    input logic             sl,
    input logic             sr,
    input logic [WIDTH-1:0] ld
  );
    case (op)
      OP_SHR:  step_op = {sr, cur[WIDTH-1:1]};
      OP_SHL:  step_op = {cur[WIDTH-2:0], sl};
      OP_LOAD: step_op = ld;
      OP_ROR:  step_op = {cur[0], cur[WIDTH-1:1]};
      OP_ROL:  step_op = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ASR:  step_op = {cur[WIDTH-1], cur[WIDTH-1:1]};
      OP_CLR:  step_op = '0;
      default: step_op = cur;
    endcase
  endfunction

  assign s_op = op_e'(s);
  // Ops whose result does not depend on a step count complete on the accept edge.
  assign fixed_op = (s_op == OP_HOLD) || (s_op == OP_LOAD) || (s_op == OP_CLR);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = s_op;
          if (fixed_op || (amt == '0)) begin
            q_d    = fixed_op ? step_op(s_op, q_q, sil, sir, p) : q_q;
            cnt_d  = '0;
            done_d = 1'b1;
          end else begin
            cnt_d   = amt;
            state_d = ST_RUN;
          end
        end else begin
          q_d = step_op(s_op, q_q, sil, sir, p);
        end
      end
      ST_RUN: begin
        q_d   = step_op(mode_q, q_q, sil, sir, p);
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= OP_HOLD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign so_r = q_q[0];
  assign so_l = q_q[WIDTH-1];
  assign busy = (state_q == ST_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8): expectations are queued as
// stimulus is applied and compared after each clock edge.
module tb_univ_shift_reg;

  localparam int W = 8;
  localparam int AW = $clog2(W);

  logic          clk;
  logic          clear_n;
  logic [2:0]    s;
  logic [W-1:0]  p;
  logic          sil;
  logic          sir;
  logic          start;
  logic [AW-1:0] amt;
  logic [W-1:0]  q;
  logic          so_r;
  logic          so_l;
  logic          busy;
  logic          done;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .s       (s),
    .p       (p),
    .sil     (sil),
    .sir     (sir),
    .start   (start),
    .amt     (amt),
    .q       (q),
    .so_r    (so_r),
    .so_l    (so_l),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    string        name;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  function automatic void sb_push(input string name, input logic [W-1:0] eq,
                                  input logic eb, input logic ed);
    exp_t x;
    x.name = name; x.q = eq; x.busy = eb; x.done = ed;
    sb.push_back(x);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic st, input logic [AW-1:0] a);
    s = op; start = st; amt = a;
  endtask

  task automatic test_reset();
    clear_n = 1'b1;
    drive(3'b000, 1'b0, '0);
    p = '0; sil = 1'b0; sir = 1'b0;
    #2 clear_n = 1'b0;
    #1;
    sb_push("reset_initial", 8'h00, 1'b0, 1'b0);
    e = sb.pop_front(); vectors++;
    if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
      miscompares++;
      $display("FAIL %s: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
               e.name, q, busy, done, e.q, e.busy, e.done);
    end
    tick();
    clear_n = 1'b1;
    // Load 0x3C, start a long shift, then abort it asynchronously mid-cycle.
    p = 8'h3C; drive(3'b011, 1'b0, '0);
    tick();
    drive(3'b001, 1'b1, 3'd5);
    sb_push("reset_accept", 8'h3C, 1'b1, 1'b0);
    tick();
    e = sb.pop_front(); vectors++;
    if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
      miscompares++;
      $display("FAIL %s: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
               e.name, q, busy, done, e.q, e.busy, e.done);
    end
    drive(3'b000, 1'b0, '0);
    #2 clear_n = 1'b0;
    #1;
    sb_push("reset_async_abort", 8'h00, 1'b0, 1'b0);
    e = sb.pop_front(); vectors++;
    if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
      miscompares++;
      $display("FAIL %s: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
               e.name, q, busy, done, e.q, e.busy, e.done);
    end
    tick();
    #2 clear_n = 1'b1;
    for (int i = 0; i < 6; i++) sb_push("reset_release_hold", 8'h00, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front(); vectors++;
      if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
        miscompares++;
        $display("FAIL %s: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                 e.name, q, busy, done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_direct();
    logic [2:0]   ops  [6] = '{3'b011, 3'b001, 3'b010, 3'b100, 3'b110, 3'b111};
    logic [W-1:0] want [6] = '{8'hA5, 8'h52, 8'hA5, 8'hD2, 8'hE9, 8'h00};
    p = 8'hA5; sil = 1'b1; sir = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], 1'b0, '0);
      sb_push($sformatf("direct_op%0d", i), want[i], 1'b0, 1'b0);
      tick();
      e = sb.pop_front(); vectors++;
      if ({q, busy, done, so_r, so_l} !== {e.q, e.busy, e.done, e.q[0], e.q[W-1]}) begin
        miscompares++;
        $display("FAIL %s: got q=%h busy=%b done=%b so_r=%b so_l=%b, want q=%h busy=%b done=%b so_r=%b so_l=%b",
                 e.name, q, busy, done, so_r, so_l, e.q, e.busy, e.done, e.q[0], e.q[W-1]);
      end
    end
  endtask

  task automatic test_multi_rotate();
    p = 8'h81; drive(3'b011, 1'b0, '0);
    tick();
    drive(3'b101, 1'b1, 3'd3);
    sb_push("rol_accept", 8'h81, 1'b1, 1'b0);
    sb_push("rol_step1",  8'h03, 1'b1, 1'b0);
    sb_push("rol_step2",  8'h06, 1'b1, 1'b0);
    sb_push("rol_done",   8'h0C, 1'b0, 1'b1);
    sb_push("rol_after",  8'h0C, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      tick();
      drive(3'b000, 1'b0, '0);
      e = sb.pop_front(); vectors++;
      if ({q, busy, done, so_r, so_l} !== {e.q, e.busy, e.done, e.q[0], e.q[W-1]}) begin
        miscompares++;
        $display("FAIL %s: got q=%h busy=%b done=%b so_r=%b so_l=%b, want q=%h busy=%b done=%b",
                 e.name, q, busy, done, so_r, so_l, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_asr_ignore();
    logic [W-1:0] want [7] = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    int n;
    p = 8'h80; drive(3'b011, 1'b0, '0);
    tick();
    drive(3'b110, 1'b1, 3'd7);
    sb_push("asr_accept", 8'h80, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++)
      sb_push($sformatf("asr_step%0d", i + 1), want[i], (i != 6), (i == 6));
    sb_push("asr_after", 8'hFF, 1'b0, 1'b0);
    n = 0;
    while (sb.size() > 0) begin
      tick();
      n++;
      // A clear request mid-run must be ignored while busy.
      if (n == 3) drive(3'b111, 1'b1, 3'd1);
      else        drive(3'b000, 1'b0, '0);
      e = sb.pop_front(); vectors++;
      if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
        miscompares++;
        $display("FAIL %s: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                 e.name, q, busy, done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_back_to_back();
    p = 8'h5A; drive(3'b011, 1'b0, '0);
    tick();
    drive(3'b001, 1'b1, 3'd0);
    sb_push("zero_len_shift", 8'h5A, 1'b0, 1'b1);
    sb_push("b2b_load",       8'h11, 1'b0, 1'b1);
    sb_push("hold_op_start",  8'h11, 1'b0, 1'b1);
    sb_push("clr_op_start",   8'h00, 1'b0, 1'b1);
    sb_push("b2b_idle",       8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      case (i)
        0: begin p = 8'h11; drive(3'b011, 1'b1, 3'd2); end
        1: drive(3'b000, 1'b1, 3'd3);
        2: drive(3'b111, 1'b1, 3'd5);
        default: drive(3'b000, 1'b0, '0);
      endcase
      e = sb.pop_front(); vectors++;
      if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
        miscompares++;
        $display("FAIL %s: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                 e.name, q, busy, done, e.q, e.busy, e.done);
      end
    end
  endtask

  task automatic test_serial_run();
    logic         sir_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] want    [4] = '{8'h80, 8'h40, 8'hA0, 8'hD0};
    drive(3'b111, 1'b0, '0);
    tick();
    drive(3'b001, 1'b1, 3'd4);
    sir = 1'b0;
    sb_push("serial_accept", 8'h00, 1'b1, 1'b0);
    tick();
    e = sb.pop_front(); vectors++;
    if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
      miscompares++;
      $display("FAIL %s: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
               e.name, q, busy, done, e.q, e.busy, e.done);
    end
    drive(3'b000, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      sir = sir_seq[i];
      sb_push($sformatf("serial_step%0d", i + 1), want[i], (i != 3), (i == 3));
      tick();
      e = sb.pop_front(); vectors++;
      if ({q, busy, done, so_l} !== {e.q, e.busy, e.done, e.q[W-1]}) begin
        miscompares++;
        $display("FAIL %s: got q=%h busy=%b done=%b so_l=%b, want q=%h busy=%b done=%b",
                 e.name, q, busy, done, so_l, e.q, e.busy, e.done);
      end
    end
    sb_push("serial_after", 8'hD0, 1'b0, 1'b0);
    tick();
    e = sb.pop_front(); vectors++;
    if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
      miscompares++;
      $display("FAIL %s: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
               e.name, q, busy, done, e.q, e.busy, e.done);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_multi_rotate();
    test_asr_ignore();
    test_back_to_back();
    test_serial_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register, the successor to the 4-bit ls74194 used in the datapath. It adds a generic WIDTH, rotate and arithmetic-shift modes, a synchronous clear, and a multi-step shift sequencer with a busy/done handshake. It serves as the shift/rotate unit next to the ALU. Direct per-cycle control in the ls74194 style is kept for simple use.

Parameters:
WIDTH, 8, register width in bits (>= 2)
AMT_W, $clog2(WIDTH), width of the shift-amount port (derived localparam, not overridden)

Ports:
clk      input   1        rising-edge clock
clear_n  input   1        asynchronous active-low reset/clear
s        input   3        operation select
p        input   WIDTH    parallel load data
sil      input   1        serial input for left shift (enters q[0])
sir      input   1        serial input for right shift (enters q[WIDTH-1])
start    input   1        request multi-step operation (sampled in IDLE only)
amt      input   AMT_W    step count for multi-step operation
q        output  WIDTH    register contents
so_r     output  1        serial out right, = q[0] (combinational)
so_l     output  1        serial out left, = q[WIDTH-1] (combinational)
busy     output  1        multi-step sequence in progress
done     output  1        one-cycle pulse: operation requested by start has completed

Behaviour:
- Reset (clear_n=0, asynchronous): q=0, busy=0, done=0, state=IDLE, internal count=0 and latched mode=0, all taking effect immediately. Any running sequence is aborted and no done pulse is produced.
- Operation codes, one step per application:
  - 000 hold
  - 001 shift right: q <= {sir, q[W-1:1]}
  - 010 shift left: q <= {q[W-2:0], sil}
  - 011 parallel load: q <= p
  - 100 rotate right: q <= {q[0], q[W-1:1]}
  - 101 rotate left: q <= {q[W-2:0], q[W-1]}
  - 110 arithmetic shift right: q <= {q[W-1], q[W-1:1]}
  - 111 synchronous clear: q <= 0
- FSM states: IDLE, RUN.
- IDLE with start=0: s is applied directly at every edge (single step). done=0, busy=0.
- IDLE with start=1 (accept edge):
  - s and amt are latched. q is unchanged on this edge; s is not applied directly.
  - amt==0, or latched op is 000/011/111: the op is applied once on this edge, done=1 for the following cycle, and the FSM stays in IDLE with busy=0. For amt==0 with a shift/rotate op, q is unchanged.
  - Otherwise: go to RUN, busy=1, count=amt.
- RUN:
  - Each edge applies the latched op once and decrements count. sil/sir are sampled live at each step.
  - On the edge where count goes 1 -> 0: return to IDLE, busy=0, done=1 for exactly one cycle.
  - Total latency from accept edge to done high is amt+1 edges.
  - s and start are ignored while busy=1.
- done is registered and deasserts on the next edge unless a new zero-length or single-cycle request completes on that edge.
- Back-to-back requests: start may be asserted in the cycle where done=1 (the FSM is IDLE) and is accepted.
- Arithmetic is pure bit movement, with no carry or overflow. Rotate by WIDTH-1 is the maximum amount.

Test Plan:
All scenarios use WIDTH=8.
1. clear_n=0 during a RUN with q=0x3C -> q=0x00, busy=0, done=0 immediately, without waiting for a clock edge. After release with s=000, q holds 0x00.
2. Direct mode sequence, one edge each:
   - load p=0xA5 -> 0xA5
   - s=001, sir=0 -> 0x52
   - s=010, sil=1 -> 0xA5
   - s=100 -> 0xD2
   - s=110 -> 0xE9
   - s=111 -> 0x00
   - so_r and so_l track q[0] and q[7] after each edge.
3. Load 0x81, then start with s=101, amt=3 -> busy high for 3 cycles after the accept edge, then q=0x0C with a single-cycle done pulse.
4. Load 0x80, then start with s=110, amt=7 -> q=0xFF and done after 8 edges. A start pulse with s=111 issued mid-run is ignored (q is not cleared).
5. start with s=001, amt=0 on q=0x5A -> q stays 0x5A, busy never asserts, done=1 for one cycle. An immediate second start with s=011, p=0x11 -> q=0x11 and done for one cycle.
6. start with s=001, amt=4, sir toggling 1,0,1,1 during RUN on q=0x00 -> q=0xD0 (final bits 1101 in the top nibble).
